shared_bus_arbiter: RTL and testbench
=====================================

Name: shared_bus_arbiter

Overview:
- Round-robin arbiter and bus sequencer for the 64-bit shared bus between NUM_REQ source devices and the single sink device B.
- Takes per-source req/ready and 64-bit data, and issues a one-hot grant.
- Muxes the granted source's data onto the sink bus and returns the sink's acceptedB as a per-source ack.
- Sits between the deviceX producers and device B, clocked in the clkA domain.

Parameters:
- NUM_REQ, 2, number of requesting devices (2..8)
- DATA_W, 64, shared bus width
- TIMEOUT_CYCLES, 16, max cycles a grant is held without acceptance (used only with ARB_TIMEOUT_EN)

Ports:
- clkA  input  1  bus clock
- reset  input  1  asynchronous, active-low reset
- req  input  NUM_REQ  per-source bus request, level, held until ack or abandon
- ready  input  NUM_REQ  per-source data-valid, meaningful only while granted
- data_in  input  NUM_REQ*DATA_W  source data, slice i = data_in[i*DATA_W +: DATA_W]
- acceptedB  input  1  sink accepts current bus word this cycle
- gnt  output  NUM_REQ  one-hot grant, registered
- ack  output  NUM_REQ  one-cycle pulse to source whose word was accepted, registered
- sharedBus  output  DATA_W  muxed data to sink
- bus_valid  output  1  sharedBus holds valid data for sink
- timeout_err  output  1  one-cycle pulse on grant timeout

Behaviour:
- Reset values (reset=0, async): state=IDLE, gnt=0, ack=0, timeout_err=0, last_grant=NUM_REQ-1 so source 0 wins first, timeout counter=0.
- sharedBus=0 and bus_valid=0 are combinational results of IDLE state.
- Reset mid-transfer: gnt drops immediately and no ack is issued.
- State IDLE:
  - If req!=0, select the first set req bit searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Load gnt one-hot for that source, capture sel index, go to GRANT.
  - Latency: req high before edge k gives gnt high after edge k.
  - If req==0, stay in IDLE with gnt=0.
- State GRANT:
  - Combinational: bus_valid = ready[sel]; sharedBus = bus_valid ? data_in slice sel : 0.
  - Accept (bus_valid & acceptedB at an edge):
    - ack[sel]=1 for one cycle, gnt=0, last_grant=sel, go to RELEASE.
  - Abandon (req[sel]=0 with no accept at an edge):
    - gnt=0, no ack, last_grant=sel, go to IDLE.
  - acceptedB while bus_valid=0: ignored.
  - Accept and req[sel] dropping on the same edge: treated as an accept, so ack is issued.
  - Requests from other sources are ignored until the grant ends.
- State RELEASE:
  - Exactly one cycle: gnt=0, bus_valid=0, sharedBus=0, ack pulse visible.
  - Then IDLE unconditionally.
  - A source still holding req in IDLE is arbitrated normally; round-robin places it last.
- Fairness: with all req high, grants rotate 0,1,..,NUM_REQ-1,0.
- Minimum turnaround: 3 cycles per transfer (GRANT, RELEASE, IDLE).
- At most one gnt bit and at most one ack bit are high in any cycle.
- gnt and ack are never high in the same cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to GRANT and increments each GRANT cycle without accept.
  - When it reaches TIMEOUT_CYCLES-1 with no accept on that edge: timeout_err pulses 1 cycle, gnt=0, no ack, last_grant=sel, go to RELEASE.
  - An accept on the same edge wins over the timeout.
- Undefined:
  - No counter; timeout_err tied 0.
  - The grant is held indefinitely until accept or abandon.

Test Plan:
- Reset release, NUM_REQ=2, req=2'b11, ready=2'b11, acceptedB=1 continuously -> gnt sequence 01,00,00,10,00,00,01... (GRANT/RELEASE/IDLE); ack[0] then ack[1]; sharedBus equals data_in slice of granted source during GRANT, 0 otherwise.
- req[0]=1 and ready[0]=0 for 3 cycles, then ready[0]=1 with data 64'hDEADBEEF_0123CAFE and acceptedB=1 -> bus_valid=0 for 3 GRANT cycles, then sharedBus=64'hDEADBEEF_0123CAFE, bus_valid=1, ack[0] pulse on the next cycle.
- Source 1 granted, drops req[1] before ready -> gnt=0 next cycle, no ack, IDLE; pending req[0] is granted next.
- reset driven low while in GRANT with bus_valid=1 -> gnt=0, bus_valid=0, sharedBus=0 immediately (asynchronous); after release source 0 has priority.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req[0]=1, ready[0]=1, acceptedB=0 -> timeout_err pulses after the 16th GRANT cycle, gnt drops, no ack; without the macro gnt stays high for 100+ cycles and timeout_err stays 0.
- acceptedB=1 while granted source has ready=0 -> no ack and state stays GRANT.

Source files
------------

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 64-bit bus into device B.
// Ports: clkA, reset (async, active-low); req/ready/data_in per source;
//   acceptedB from sink; gnt/ack one-hot per source (registered);
//   sharedBus/bus_valid to sink; timeout_err pulse.
// Optional: define ARB_TIMEOUT_EN to abort grants held TIMEOUT_CYCLES cycles.
module shared_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clkA,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          ready,
    input  logic [NUM_REQ*DATA_W-1:0]   data_in,
    input  logic                        acceptedB,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           sharedBus,
    output logic                        bus_valid,
    output logic                        timeout_err
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   pick;
    logic            accept;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("shared_bus_arbiter: unsupported parameter set");
    end

    // Search starts just after the last granted source so it goes last.
    always_comb begin
        logic [IW-1:0] idx;
        logic          found;
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign bus_valid = (state == GRANT) && ready[sel];
    assign sharedBus = bus_valid ? data_in[int'(sel)*DATA_W +: DATA_W]
                                 : '0;
    assign accept    = bus_valid && acceptedB;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            gnt         <= '0;
            ack         <= '0;
            sel         <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            cnt         <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= NUM_REQ'(1) << pick;
                        sel   <= pick;
                        state <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    // Accept wins over both abandon and timeout.
                    if (accept) begin
                        ack        <= NUM_REQ'(1) << sel;
                        gnt        <= '0;
                        last_grant <= sel;
                        state      <= RELEASE;
                    end else if (!req[sel]) begin
                        gnt        <= '0;
                        last_grant <= sel;
                        state      <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        gnt         <= '0;
                        last_grant  <= sel;
                        state       <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RELEASE: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (NUM_REQ=2, DATA_W=64).
// Accepted words are scoreboarded and matched against ack pulses.
module tb_shared_bus_arbiter;

    logic         clkA;
    logic         reset;
    logic [1:0]   req;
    logic [1:0]   ready;
    logic [127:0] data_in;
    logic         acceptedB;
    logic [1:0]   gnt;
    logic [1:0]   ack;
    logic [63:0]  sharedBus;
    logic         bus_valid;
    logic         timeout_err;

    typedef struct {
        int          src;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DB = 64'hBBBB_0000_CCCC_5555;
    localparam logic [63:0] DD = 64'hDEADBEEF_0123CAFE;
    localparam logic [63:0] DE = 64'h0E0E_0E0E_1234_5678;
    localparam logic [63:0] DF = 64'hF00D_FACE_9999_0001;

    shared_bus_arbiter #(
        .NUM_REQ(2),
        .DATA_W(64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clkA(clkA),
        .reset(reset),
        .req(req),
        .ready(ready),
        .data_in(data_in),
        .acceptedB(acceptedB),
        .gnt(gnt),
        .ack(ack),
        .sharedBus(sharedBus),
        .bus_valid(bus_valid),
        .timeout_err(timeout_err)
    );

    initial clkA = 1'b0;
    always #5 clkA = ~clkA;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; checks invariants and matches any ack with the scoreboard.
    task automatic step();
        logic [63:0] pb;
        logic        pa;
        exp_t        e;
        pb = sharedBus;
        pa = bus_valid & acceptedB;
        @(posedge clkA);
        #1;
        chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
        chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
        chk("gnt_ack_excl", 64'(|(gnt & ack)), 64'd0);
        if (ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("ack_spurious", 64'(ack), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_src", 64'(ack), 64'(1) << e.src);
                chk("ack_word", pb, e.data);
                chk("ack_after_accept", 64'(pa), 64'd1);
            end
        end
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  eg [7];
        logic [1:0]  ea [7];
        logic [63:0] eb;
        eg = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        ea = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

        reset = 1'b0;
        req = '0;
        ready = '0;
        acceptedB = 1'b0;
        data_in = '0;
        #2;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_valid", 64'(bus_valid), 64'd0);
        chk("rst_bus", sharedBus, 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);

        // Continuous traffic from both sources: strict rotation.
        @(posedge clkA);
        #1;
        data_in = {DB, DA};
        req = 2'b11;
        ready = 2'b11;
        acceptedB = 1'b1;
        reset = 1'b1;
        sb.push_back('{0, DA});
        sb.push_back('{1, DB});
        for (int c = 0; c < 7; c++) begin
            step();
            chk("rr_gnt", 64'(gnt), 64'(eg[c]));
            chk("rr_ack", 64'(ack), 64'(ea[c]));
            eb = eg[c][0] ? DA : (eg[c][1] ? DB : 64'd0);
            chk("rr_bus", sharedBus, eb);
            chk("rr_valid", 64'(bus_valid), 64'(|eg[c]));
        end
        req = '0;
        ready = '0;
        acceptedB = 1'b0;
        step();
        chk("rr_abandon_gnt", 64'(gnt), 64'd0);
        step();
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);

        // Granted source not ready: acceptedB ignored until ready.
        data_in[63:0] = DD;
        req = 2'b01;
        ready = 2'b00;
        acceptedB = 1'b1;
        step();
        chk("wait_gnt", 64'(gnt), 64'd1);
        chk("wait_valid", 64'(bus_valid), 64'd0);
        chk("wait_bus", sharedBus, 64'd0);
        repeat (2) begin
            step();
            chk("wait_hold_gnt", 64'(gnt), 64'd1);
            chk("wait_no_ack", 64'(ack), 64'd0);
            chk("wait_valid_lo", 64'(bus_valid), 64'd0);
        end
        ready = 2'b01;
        #1;
        chk("wait_valid_hi", 64'(bus_valid), 64'd1);
        chk("wait_bus_data", sharedBus, DD);
        sb.push_back('{0, DD});
        step();
        chk("wait_ack", 64'(ack), 64'd1);
        chk("wait_gnt_off", 64'(gnt), 64'd0);
        req = '0;
        ready = '0;
        acceptedB = 1'b0;
        step();
        chk("wait_ack_pulse", 64'(ack), 64'd0);
        chk("wait_sb_empty", 64'(sb.size()), 64'd0);

        // Source 1 abandons; pending source 0 goes next.
        req = 2'b11;
        step();
        chk("ab_gnt1", 64'(gnt), 64'd2);
        step();
        chk("ab_hold1", 64'(gnt), 64'd2);
        req = 2'b01;
        step();
        chk("ab_gnt_off", 64'(gnt), 64'd0);
        chk("ab_no_ack", 64'(ack), 64'd0);
        step();
        chk("ab_gnt0", 64'(gnt), 64'd1);

        // Asynchronous reset while driving a valid word.
        data_in[63:0] = DE;
        ready = 2'b01;
        #1;
        chk("ar_valid", 64'(bus_valid), 64'd1);
        chk("ar_bus", sharedBus, DE);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_gnt", 64'(gnt), 64'd0);
        chk("ar_valid_lo", 64'(bus_valid), 64'd0);
        chk("ar_bus_lo", sharedBus, 64'd0);
        chk("ar_ack", 64'(ack), 64'd0);
        @(posedge clkA);
        #1;
        req = 2'b11;
        ready = 2'b00;
        reset = 1'b1;
        step();
        chk("ar_prio0", 64'(gnt), 64'd1);
        req = 2'b00;
        step();
        chk("ar_abandon", 64'(gnt), 64'd0);

        // Accept and req drop on the same edge still acks.
        req = 2'b10;
        step();
        chk("ad_gnt1", 64'(gnt), 64'd2);
        data_in[127:64] = DF;
        ready = 2'b10;
        acceptedB = 1'b1;
        req = 2'b00;
        #1;
        chk("ad_valid", 64'(bus_valid), 64'd1);
        sb.push_back('{1, DF});
        step();
        chk("ad_ack", 64'(ack), 64'd2);
        chk("ad_gnt_off", 64'(gnt), 64'd0);
        acceptedB = 1'b0;
        ready = 2'b00;
        step();
        chk("ad_ack_pulse", 64'(ack), 64'd0);
        step();

        // Grant held with no acceptance.
        data_in[63:0] = DA;
        req = 2'b01;
        ready = 2'b01;
        acceptedB = 1'b0;
        step();
        chk("to_gnt", 64'(gnt), 64'd1);
        chk("to_bus", sharedBus, DA);
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            step();
            chk("to_hold", 64'(gnt), 64'd1);
            chk("to_terr_lo", 64'(timeout_err), 64'd0);
        end
        step();
        chk("to_terr_hi", 64'(timeout_err), 64'd1);
        chk("to_gnt_off", 64'(gnt), 64'd0);
        chk("to_no_ack", 64'(ack), 64'd0);
        step();
        chk("to_terr_pulse", 64'(timeout_err), 64'd0);
        chk("to_release", 64'(gnt), 64'd0);
        req = 2'b00;
        step();
        chk("to_idle", 64'(gnt), 64'd0);
`else
        for (int c = 0; c < 110; c++) begin
            step();
            chk("nto_hold", 64'(gnt), 64'd1);
            chk("nto_terr", 64'(timeout_err), 64'd0);
        end
        req = 2'b00;
        step();
        chk("nto_abandon", 64'(gnt), 64'd0);
        chk("nto_no_ack", 64'(ack), 64'd0);
`endif
        step();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
